// File: rtl/sample_minmax_tracker.sv
// Running max/min tracker over fixed windows of WINDOW valid ADC samples.
// Each completed window's result is held pending and published to the
// overlay outputs only on a frame_start pulse, so values never change mid-frame.
module sample_minmax_tracker #(
    parameter int DATA_W = 12,
    parameter int WINDOW = 4096,
    parameter int CNT_W  = $clog2(WINDOW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              frame_start,
    input  logic              clear,
    output logic [DATA_W-1:0] v_max,
    output logic [DATA_W-1:0] v_min,
    output logic              stats_valid,
    output logic              overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   run_max_q, run_max_d;
    logic [DATA_W-1:0]   run_min_q, run_min_d;
    logic [DATA_W-1:0]   pend_max_q, pend_max_d;
    logic [DATA_W-1:0]   pend_min_q, pend_min_d;
    logic                pending_q, pending_d;
    logic [DATA_W-1:0]   v_max_q, v_max_d;
    logic [DATA_W-1:0]   v_min_q, v_min_d;
    logic                stats_valid_q, stats_valid_d;
    logic                overrun_q, overrun_d;

    logic                publish;
    logic                complete;
    logic [DATA_W-1:0]   nxt_max;
    logic [DATA_W-1:0]   nxt_min;

    // Event decode: publish uses the pending flag held before this edge;
    // completion is the sample that lands while cnt sits at WINDOW-1.
    always_comb begin
        publish  = frame_start && pending_q;
        complete = sample_valid && (state_q == ACCUM) && (cnt_q == CNT_LAST);
        nxt_max  = (sample > run_max_q) ? sample : run_max_q;
        nxt_min  = (sample < run_min_q) ? sample : run_min_q;
    end

    // Next-state logic for the window FSM, pending result and published outputs.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it
        // unassigned and no latch is inferred.
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        pend_max_d    = pend_max_q;
        pend_min_d    = pend_min_q;
        pending_d     = pending_q;
        v_max_d       = v_max_q;
        v_min_d       = v_min_q;
        stats_valid_d = stats_valid_q;
        overrun_d     = 1'b0;

        if (clear) begin
            // Abort the window and drop any pending result; published outputs hold.
            state_d   = EMPTY;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (publish) begin
                v_max_d       = pend_max_q;
                v_min_d       = pend_min_q;
                stats_valid_d = 1'b1;
                pending_d     = 1'b0;
            end

            if (sample_valid) begin
                if (state_q == EMPTY) begin
                    run_max_d = sample;
                    run_min_d = sample;
                    cnt_d     = CNT_ONE;
                    state_d   = ACCUM;
                end else if (complete) begin
                    // Last sample is folded into the result, which waits for the
                    // next frame_start even if one arrives on this same edge.
                    pend_max_d = nxt_max;
                    pend_min_d = nxt_min;
                    pending_d  = 1'b1;
                    overrun_d  = pending_q && !publish;
                    cnt_d      = '0;
                    state_d    = EMPTY;
                end else begin
                    run_max_d = nxt_max;
                    run_min_d = nxt_min;
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Register all state with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= EMPTY;
            cnt_q         <= '0;
            run_max_q     <= '0;
            run_min_q     <= '0;
            pend_max_q    <= '0;
            pend_min_q    <= '0;
            pending_q     <= 1'b0;
            v_max_q       <= '0;
            v_min_q       <= '0;
            stats_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            pend_max_q    <= pend_max_d;
            pend_min_q    <= pend_min_d;
            pending_q     <= pending_d;
            v_max_q       <= v_max_d;
            v_min_q       <= v_min_d;
            stats_valid_q <= stats_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign v_max       = v_max_q;
    assign v_min       = v_min_q;
    assign stats_valid = stats_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sample_minmax_tracker.sv
// Self-checking bench for sample_minmax_tracker with WINDOW=4.
// Each vector gives the inputs for one clock edge and the outputs expected
// just after that edge; expectations go through a scoreboard queue.
module tb_sample_minmax_tracker;

    localparam int DATA_W = 12;
    localparam int WINDOW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              sample_valid = 1'b0;
    logic              frame_start = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] v_max;
    logic [DATA_W-1:0] v_min;
    logic              stats_valid;
    logic              overrun;

    sample_minmax_tracker #(
        .DATA_W(DATA_W),
        .WINDOW(WINDOW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .frame_start (frame_start),
        .clear       (clear),
        .v_max       (v_max),
        .v_min       (v_min),
        .stats_valid (stats_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rst_n;
        logic              sv;
        logic [DATA_W-1:0] smp;
        logic              fs;
        logic              clr;
        logic [DATA_W-1:0] e_max;
        logic [DATA_W-1:0] e_min;
        logic              e_stv;
        logic              e_ovr;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    function automatic vec_t mk(input logic r, input logic sv, input int smp,
                                input logic fs, input logic clr, input int emax,
                                input int emin, input logic estv, input logic eovr);
        vec_t v;
        v.rst_n = r;
        v.sv    = sv;
        v.smp   = DATA_W'(smp);
        v.fs    = fs;
        v.clr   = clr;
        v.e_max = DATA_W'(emax);
        v.e_min = DATA_W'(emin);
        v.e_stv = estv;
        v.e_ovr = eovr;
        return v;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step_no, act, exp);
        end
    endtask

    // Drive one vector mid-cycle, push its expectation, compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n        = v.rst_n;
        sample_valid = v.sv;
        sample       = v.smp;
        frame_start  = v.fs;
        clear        = v.clr;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard step %0d: queue empty", step_no);
        end else begin
            e = sb_q.pop_front();
            check("v_max", v_max, e.e_max);
            check("v_min", v_min, e.e_min);
            check("stats_valid", {{(DATA_W-1){1'b0}}, stats_valid}, {{(DATA_W-1){1'b0}}, e.e_stv});
            check("overrun", {{(DATA_W-1){1'b0}}, overrun}, {{(DATA_W-1){1'b0}}, e.e_ovr});
        end
    endtask

    // Shorthand: a plain valid sample with outputs expected to hold.
    task automatic smp_hold(input int s, input int emax, input int emin, input logic estv);
        step(mk(1, 1, s, 0, 0, emax, emin, estv, 0));
    endtask

    initial begin
        // Reset and windows 1..4 as a table.
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0,    0, 0));
        // Window 100,4000,7,2048 then publish
        tbl.push_back(mk(1, 1, 100,  0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 4000, 0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 7,    0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 2048, 0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 0, 0,    1, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 4000, 7,    1, 0));
        // Window with gaps: 10, idle x3, 20, 30, 5
        tbl.push_back(mk(1, 1, 10,   0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 0, 999,  0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 1, 20,   0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 1, 30,   0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 1, 5,    0, 0, 4000, 7,    1, 0));
        tbl.push_back(mk(1, 0, 0,    1, 0, 30,   5,    1, 0));
        // Fresh reset, then 0xFFF x4 with frame_start on the last sample
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 4095, 0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 4095, 0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 4095, 0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 1, 4095, 1, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 0,    0,    0, 0));
        tbl.push_back(mk(1, 0, 0,    1, 0, 4095, 4095, 1, 0));
        // Two windows without frame_start: overrun on second completion
        tbl.push_back(mk(1, 1, 500,  0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 1,    0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 2,    0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 3,    0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 600,  0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 10,   0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 20,   0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 1, 30,   0, 0, 4095, 4095, 1, 1));
        tbl.push_back(mk(1, 0, 0,    0, 0, 4095, 4095, 1, 0));
        tbl.push_back(mk(1, 0, 0,    1, 0, 600,  10,   1, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Clear mid-window: partial 50,50 discarded, outputs hold through clear.
        smp_hold(50, 600, 10, 1);
        smp_hold(50, 600, 10, 1);
        step(mk(1, 0, 0, 0, 1, 600, 10, 1, 0));
        for (int i = 0; i < 4; i++) smp_hold(9, 600, 10, 1);
        step(mk(1, 0, 0, 1, 0, 9, 9, 1, 0));

        // Clear beats frame_start and sample_valid on the same edge.
        smp_hold(1, 9, 9, 1);
        smp_hold(2, 9, 9, 1);
        smp_hold(3, 9, 9, 1);
        smp_hold(4, 9, 9, 1);
        step(mk(1, 1, 77, 1, 1, 9, 9, 1, 0));
        step(mk(1, 0, 0, 1, 0, 9, 9, 1, 0));

        // Reset after 3 samples; next 4 samples form a fresh window.
        smp_hold(7, 9, 9, 1);
        smp_hold(8, 9, 9, 1);
        smp_hold(9, 9, 9, 1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        smp_hold(200, 0, 0, 0);
        smp_hold(300, 0, 0, 0);
        smp_hold(100, 0, 0, 0);
        smp_hold(250, 0, 0, 0);
        step(mk(1, 0, 0, 1, 0, 300, 100, 1, 0));

        // Completion with pending=1 and same-edge frame_start: old result
        // publishes, new one waits, no overrun.
        smp_hold(11, 300, 100, 1);
        smp_hold(12, 300, 100, 1);
        smp_hold(13, 300, 100, 1);
        smp_hold(14, 300, 100, 1);
        smp_hold(40, 300, 100, 1);
        smp_hold(41, 300, 100, 1);
        smp_hold(42, 300, 100, 1);
        step(mk(1, 1, 43, 1, 0, 14, 11, 1, 0));
        step(mk(1, 0, 0, 0, 0, 14, 11, 1, 0));
        step(mk(1, 0, 0, 1, 0, 43, 40, 1, 0));
        step(mk(1, 0, 0, 1, 0, 43, 40, 1, 0));

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
